// File: rtl/load_store_unit.sv
// RV32I load/store engine: one request at a time, effective-address + legality check, dmem drive, load extend.
// Latency: fault T+1, store T+2, load T+2+READ_LATENCY; req_ready only in IDLE (no pipelining).
module load_store_unit #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_store_data,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data,
  output logic        resp_we,
  output logic        resp_misaligned,
  output logic        resp_illegal,
  output logic        busy,
  output logic        dmem_wren,
  output logic [2:0]  dmem_funct3,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_data_in,
  input  logic [31:0] dmem_data_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESPOND} state_t;

  typedef struct packed {
    logic       is_store;
    logic [2:0] funct3;
    logic [1:0] lane;
    logic [4:0] rd;
  } req_t;

  state_t      state;
  req_t        req_q;
  logic [2:0]  wait_cnt;
  logic [31:0] ea;
  logic        illegal;
  logic        misaligned;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_comb begin
    ea = req_base + req_offset;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = req_is_store;
      default:                illegal = 1'b1;
    endcase
    // Illegal wins: misaligned is only reported for a legal encoding.
    misaligned = 1'b0;
    if (!illegal) begin
      case (req_funct3[1:0])
        2'b01:   misaligned = ea[0];
        2'b10:   misaligned = |ea[1:0];
        default: misaligned = 1'b0;
      endcase
    end
  end

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return word;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      req_q           <= '0;
      wait_cnt        <= '0;
      resp_valid      <= 1'b0;
      resp_rd         <= '0;
      resp_data       <= '0;
      resp_we         <= 1'b0;
      resp_misaligned <= 1'b0;
      resp_illegal    <= 1'b0;
      dmem_wren       <= 1'b0;
      dmem_funct3     <= '0;
      dmem_address    <= '0;
      dmem_data_in    <= '0;
    end else begin
      resp_valid      <= 1'b0;
      resp_rd         <= '0;
      resp_data       <= '0;
      resp_we         <= 1'b0;
      resp_misaligned <= 1'b0;
      resp_illegal    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_q <= '{is_store: req_is_store, funct3: req_funct3, lane: ea[1:0], rd: req_rd};
            if (illegal || misaligned) begin
              state           <= RESPOND;
              resp_valid      <= 1'b1;
              resp_rd         <= req_rd;
              resp_illegal    <= illegal;
              resp_misaligned <= misaligned;
            end else begin
              // Loads always fetch the whole aligned word; lane select happens on return.
              state        <= ACCESS;
              dmem_wren    <= req_is_store;
              dmem_funct3  <= req_is_store ? req_funct3 : 3'b010;
              dmem_address <= req_is_store ? ea : {ea[31:2], 2'b00};
              dmem_data_in <= req_is_store ? req_store_data : 32'b0;
            end
          end
        end
        ACCESS: begin
          if (req_q.is_store) begin
            state        <= RESPOND;
            dmem_wren    <= 1'b0;
            dmem_funct3  <= '0;
            dmem_address <= '0;
            dmem_data_in <= '0;
            resp_valid   <= 1'b1;
            resp_rd      <= req_q.rd;
          end else begin
            state    <= WAIT;
            wait_cnt <= 3'(READ_LATENCY - 1);
          end
        end
        WAIT: begin
          if (wait_cnt == 3'd0) begin
            state        <= RESPOND;
            dmem_funct3  <= '0;
            dmem_address <= '0;
            resp_valid   <= 1'b1;
            resp_rd      <= req_q.rd;
            resp_data    <= load_extend(req_q.funct3, req_q.lane, dmem_data_out);
            resp_we      <= (req_q.rd != 5'd0);
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
